// File: rtl/enemy_life_ctrl.sv
// ============================================================================
//  Module      : enemy_life_ctrl
//  Description : Per-enemy life/respawn controller. Counts hits on the rising
//                edge of the collision flag, runs a death blink, a respawn
//                countdown and a respawn budget, and pulses feedback to the
//                bullet stage and a kill strobe to the score logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_life_ctrl #(
  parameter int HIT_POINTS     = 3,
  parameter int BLINK_FRAMES   = 30,
  parameter int RESPAWN_FRAMES = 120,
  parameter int BLINK_SHIFT    = 2,
  parameter int MAX_RESPAWNS   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frameTick,
  input  logic       enable,
  input  logic       collisionFlag,
  output logic       enemyPresent,
  output logic       collisionFeedback,
  output logic       killPulse,
  output logic [2:0] hitPoints,
  output logic [1:0] enemyState
);

  // Encoded life states; the encoding is exported directly on enemyState.
  typedef enum logic [1:0] {
    ST_ALIVE = 2'b00,
    ST_DYING = 2'b01,
    ST_DEAD  = 2'b10,
    ST_GONE  = 2'b11
  } state_t;

  // Parameter values sized to the registers they are compared against.
  localparam logic [2:0] c_HIT_POINTS   = 3'(HIT_POINTS);
  localparam logic [7:0] c_BLINK_LAST   = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] c_RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
  localparam logic [2:0] c_MAX_RESPAWNS = 3'(MAX_RESPAWNS);

  state_t     r_state;
  logic [2:0] r_hitPoints;
  logic [7:0] r_frameCnt;
  logic [2:0] r_respawnCnt;
  logic       r_colReg;
  logic       r_feedback;
  logic       r_kill;

  logic       w_hit;
  logic       w_frameLastBlink;
  logic       w_frameLastRespawn;
  logic       w_respawnAllowed;
  logic       w_blinkVisible;
  logic       w_present;

  // A hit is a fresh rising edge of the flag while the game runs and the
  // enemy can be hit. Because r_colReg tracks the flag even while disabled,
  // a flag already high when enable returns is not mistaken for a new edge.
  assign w_hit = collisionFlag & ~r_colReg & enable & (r_state == ST_ALIVE);

  assign w_frameLastBlink   = (r_frameCnt == c_BLINK_LAST);
  assign w_frameLastRespawn = (r_frameCnt == c_RESPAWN_LAST);
  assign w_respawnAllowed   = (r_respawnCnt < c_MAX_RESPAWNS);
  assign w_blinkVisible     = ~r_frameCnt[BLINK_SHIFT];

  // Delay the collision flag by one cycle for edge detection, independent of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_colReg <= 1'b0;
    end else begin
      r_colReg <= collisionFlag;
    end
  end

  // Life-cycle FSM with its counters and one-cycle output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_ALIVE;
      r_hitPoints  <= c_HIT_POINTS;
      r_frameCnt   <= 8'd0;
      r_respawnCnt <= 3'd0;
      r_feedback   <= 1'b0;
      r_kill       <= 1'b0;
    end else begin
      // Pulses fall back to zero unless re-asserted below this cycle.
      r_feedback <= 1'b0;
      r_kill     <= 1'b0;
      if (enable) begin
        case (r_state)
          ST_ALIVE: begin
            // frameTick is deliberately ignored while alive.
            if (w_hit) begin
              r_feedback <= 1'b1;
              if (r_hitPoints == 3'd1) begin
                r_kill      <= 1'b1;
                r_hitPoints <= 3'd0;
                r_frameCnt  <= 8'd0;
                r_state     <= ST_DYING;
              end else begin
                r_hitPoints <= r_hitPoints - 3'd1;
              end
            end
          end
          ST_DYING: begin
            if (frameTick) begin
              if (w_frameLastBlink) begin
                r_frameCnt <= 8'd0;
                r_state    <= w_respawnAllowed ? ST_DEAD : ST_GONE;
              end else begin
                r_frameCnt <= r_frameCnt + 8'd1;
              end
            end
          end
          ST_DEAD: begin
            if (frameTick) begin
              if (w_frameLastRespawn) begin
                r_frameCnt   <= 8'd0;
                r_hitPoints  <= c_HIT_POINTS;
                r_respawnCnt <= r_respawnCnt + 3'd1;
                r_state      <= ST_ALIVE;
              end else begin
                r_frameCnt <= r_frameCnt + 8'd1;
              end
            end
          end
          default: begin
            // GONE is terminal; only reset leaves it.
            r_state <= ST_GONE;
          end
        endcase
      end
    end
  end

  // Visibility is a pure decode of registered state, so no input reaches it combinationally.
  always_comb begin
    w_present = 1'b0;
    case (r_state)
      ST_ALIVE: w_present = 1'b1;
      ST_DYING: w_present = w_blinkVisible;
      default:  w_present = 1'b0;
    endcase
  end

  assign enemyPresent      = w_present;
  assign collisionFeedback = r_feedback;
  assign killPulse         = r_kill;
  assign hitPoints         = r_hitPoints;
  assign enemyState        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_enemy_life_ctrl.sv
// ============================================================================
//  Module      : tb_enemy_life_ctrl
//  Description : Self-checking bench for enemy_life_ctrl using a table of
//                directed single-cycle vectors plus hand-written sequences
//                for blinking, respawn countdown, budget exhaustion, reset
//                and freeze behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enemy_life_ctrl;

  localparam logic [1:0] c_ALIVE = 2'b00;
  localparam logic [1:0] c_DYING = 2'b01;
  localparam logic [1:0] c_DEAD  = 2'b10;
  localparam logic [1:0] c_GONE  = 2'b11;

  logic       clk;
  logic       reset;
  logic       frameTick;
  logic       enable;
  logic       collisionFlag;
  logic       enemyPresent;
  logic       collisionFeedback;
  logic       killPulse;
  logic [2:0] hitPoints;
  logic [1:0] enemyState;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       ft;
    logic       en;
    logic       cf;
    logic       pres;
    logic       fb;
    logic       kill;
    logic [2:0] hp;
    logic [1:0] st;
  } vec_t;

  vec_t vecs [14];

  enemy_life_ctrl #(
    .HIT_POINTS    (3),
    .BLINK_FRAMES  (30),
    .RESPAWN_FRAMES(120),
    .BLINK_SHIFT   (2),
    .MAX_RESPAWNS  (3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .frameTick        (frameTick),
    .enable           (enable),
    .collisionFlag    (collisionFlag),
    .enemyPresent     (enemyPresent),
    .collisionFeedback(collisionFeedback),
    .killPulse        (killPulse),
    .hitPoints        (hitPoints),
    .enemyState       (enemyState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic pres, input logic fb,
                       input logic kill, input logic [2:0] hp, input logic [1:0] st);
    n_checks++;
    if (enemyPresent !== pres || collisionFeedback !== fb || killPulse !== kill ||
        hitPoints !== hp || enemyState !== st) begin
      n_fail++;
      $display("FAIL %s: got pres=%b fb=%b kill=%b hp=%0d st=%b, expected pres=%b fb=%b kill=%b hp=%0d st=%b",
               name, enemyPresent, collisionFeedback, killPulse, hitPoints, enemyState,
               pres, fb, kill, hp, st);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic step(input logic ft, input logic en, input logic cf);
    @(negedge clk);
    frameTick     = ft;
    enable        = en;
    collisionFlag = cf;
    @(posedge clk);
    #1;
  endtask

  // Land 'hits' separate hits on an alive enemy; the last one must kill.
  task automatic kill_enemy(input int hits);
    for (int i = 0; i < hits; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (i == hits - 1)
        check("kill_hit", 1'b1, 1'b1, 1'b1, 3'd0, c_DYING);
      else
        check("hit", 1'b1, 1'b1, 1'b0, 3'(hits - 1 - i), c_ALIVE);
      step(1'b0, 1'b1, 1'b0);
    end
  endtask

  // 30 frame ticks through the blink; hits offered in between must be ignored.
  task automatic run_dying(input logic [1:0] end_state);
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, 1'b1, 1'b0);
      if (k < 30)
        check("blink", ((k >> 2) & 1) == 0, 1'b0, 1'b0, 3'd0, c_DYING);
      else
        check("blink_end", 1'b0, 1'b0, 1'b0, 3'd0, end_state);
      step(1'b0, 1'b1, (k % 2) == 1);
      if (k == 1)
        check("dying_hit_ignored", 1'b1, 1'b0, 1'b0, 3'd0, c_DYING);
    end
    step(1'b0, 1'b1, 1'b0);
  endtask

  // 120 frame ticks in DEAD with the collision flag toggling between ticks.
  task automatic run_dead();
    for (int k = 1; k <= 120; k++) begin
      step(1'b0, 1'b1, (k % 2) == 1);
      check("dead_no_pulse", 1'b0, 1'b0, 1'b0, 3'd0, c_DEAD);
      step(1'b1, 1'b1, 1'b0);
      if (k < 120)
        check("dead_count", 1'b0, 1'b0, 1'b0, 3'd0, c_DEAD);
      else
        check("respawn", 1'b1, 1'b0, 1'b0, 3'd3, c_ALIVE);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    frameTick     = 1'b0;
    enable        = 1'b0;
    collisionFlag = 1'b0;

    //              ft    en    cf    pres  fb    kill  hp    st
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, c_ALIVE};  // first edge
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, c_ALIVE};  // held high
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, c_ALIVE};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, c_ALIVE};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, c_ALIVE};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, c_ALIVE};  // drop flag
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, c_ALIVE};  // tick ignored
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, c_ALIVE};  // second hit
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, c_ALIVE};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, c_ALIVE};  // edge while disabled
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, c_ALIVE};  // already high at enable
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, c_ALIVE};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, c_DYING};  // kill with tick
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, c_DYING};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    #1;
    check("reset_state", 1'b1, 1'b0, 1'b0, 3'd3, c_ALIVE);

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].ft, vecs[i].en, vecs[i].cf);
      check($sformatf("vec%0d", i), vecs[i].pres, vecs[i].fb, vecs[i].kill,
            vecs[i].hp, vecs[i].st);
    end

    // First death: blink then DEAD, then respawn.
    run_dying(c_DEAD);
    run_dead();

    // Rising edge on the first ALIVE cycle after respawn counts as a hit.
    step(1'b0, 1'b1, 1'b1);
    check("hit_on_respawn", 1'b1, 1'b1, 1'b0, 3'd2, c_ALIVE);
    step(1'b0, 1'b1, 1'b0);

    // Second and third deaths respawn; the fourth exhausts the budget.
    kill_enemy(2);
    run_dying(c_DEAD);
    run_dead();
    kill_enemy(3);
    run_dying(c_DEAD);
    run_dead();
    kill_enemy(3);
    run_dying(c_GONE);

    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, (k % 2) == 0);
      check("gone_terminal", 1'b0, 1'b0, 1'b0, 3'd0, c_GONE);
    end

    // Reset out of GONE, then reset in the middle of a blink.
    @(negedge clk);
    collisionFlag = 1'b0;
    frameTick     = 1'b0;
    reset         = 1'b1;
    #1;
    check("reset_from_gone", 1'b1, 1'b0, 1'b0, 3'd3, c_ALIVE);
    @(negedge clk);
    reset = 1'b0;
    kill_enemy(3);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0);
    check("mid_dying", 1'b0, 1'b0, 1'b0, 3'd0, c_DYING);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_mid_dying", 1'b1, 1'b0, 1'b0, 3'd3, c_ALIVE);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    check("after_reset", 1'b1, 1'b0, 1'b0, 3'd3, c_ALIVE);

    // Freeze: take one hit, then disable through an edge and 200 ticks.
    step(1'b0, 1'b1, 1'b1);
    check("pre_freeze_hit", 1'b1, 1'b1, 1'b0, 3'd2, c_ALIVE);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 200; k++) begin
      step(1'b1, 1'b0, k >= 5);
      check("frozen", 1'b1, 1'b0, 1'b0, 3'd2, c_ALIVE);
    end
    step(1'b0, 1'b1, 1'b1);
    check("stale_flag_after_enable", 1'b1, 1'b0, 1'b0, 3'd2, c_ALIVE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
